// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data-memory responder for the Memory stage.
// A load or store is captured on its first cycle. The pipeline is stalled
// for 1 + LATENCY cycles. The access completes on the last BUSY edge, and
// one DONE cycle lets the pipeline advance past the served request.
module dmem_responder #(
    parameter int DEPTH   = 64,
    parameter int ADDR_W  = 6,
    parameter int LATENCY = 2,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] rdata,
    output logic        stall_mem,
    output logic        misalign_err,
    output logic [15:0] test_value
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t              state_r;
    state_t              state_next_s;
    logic [CNT_W-1:0]    cnt_r;
    logic                cap_we_r;
    logic [ADDR_W-1:0]   cap_idx_r;
    logic [31:0]         cap_wdata_r;
    logic [31:0]         rdata_r;
    logic                misalign_r;
    logic [31:0]         mem_r [DEPTH];
    logic                access_now_s;

    // The access fires on the last BUSY cycle, once the latency count is exhausted.
    assign access_now_s = (state_r == BUSY) && (cnt_r == CNT_ZERO);

    // State register; reset abandons any in-flight access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and stall decode; the stall is combinational so a new request stalls at once.
    always_comb begin
        state_next_s = state_r;
        stall_mem    = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    stall_mem    = 1'b1;
                    state_next_s = BUSY;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                stall_mem = 1'b1;
                if (cnt_r == CNT_ZERO) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = BUSY;
                end
            end
            DONE: begin
                // A request still held here is the one just served, so it is not re-captured.
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Request capture, latency countdown, and the single memory access per request.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r       <= CNT_ZERO;
            cap_we_r    <= 1'b0;
            cap_idx_r   <= {ADDR_W{1'b0}};
            cap_wdata_r <= 32'h0000_0000;
            rdata_r     <= 32'h0000_0000;
            misalign_r  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 32'h0000_0000;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        cap_we_r    <= req_we;
                        cap_idx_r   <= req_addr[ADDR_W+1:2];
                        cap_wdata_r <= req_wdata;
                        cnt_r       <= CNT_LOAD;
                        // Sticky: once set, only reset clears it.
                        if (req_addr[1:0] != 2'b00) begin
                            misalign_r <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (!access_now_s) begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end else if (cap_we_r) begin
                        mem_r[cap_idx_r] <= cap_wdata_r;
                    end else begin
                        rdata_r <= mem_r[cap_idx_r];
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign rdata        = rdata_r;
    assign misalign_err = misalign_r;
    assign test_value   = mem_r[0][15:0];

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder. A reference word store plus a queue of
// expected load data supply every expected value. Load results are popped
// from the queue in the DONE cycle of each access.
module tb_dmem_responder;

    localparam int LATENCY = 2;
    localparam int BOUND   = 20;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] rdata;
    logic        stall_mem;
    logic        misalign_err;
    logic [15:0] test_value;

    int          total;
    int          passed;
    logic [31:0] model_mem [64];
    logic [31:0] last_rdata;
    logic        exp_mis;
    logic [31:0] sb [$];

    dmem_responder #(
        .DEPTH  (64),
        .ADDR_W (6),
        .LATENCY(LATENCY),
        .CNT_W  (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rdata       (rdata),
        .stall_mem   (stall_mem),
        .misalign_err(misalign_err),
        .test_value  (test_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Advance one clock and settle well away from the next edge.
    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) model_mem[i] = 32'h0;
        last_rdata = 32'h0;
        exp_mis    = 1'b0;
    endtask

    // Full request handshake: raise the request, count stall cycles,
    // check outputs in DONE, then drop the request.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input string tag);
        int n;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        if (addr[1:0] != 2'b00) exp_mis = 1'b1;
        if (!we) sb.push_back(model_mem[addr[7:2]]);
        #1;
        n = 0;
        while (stall_mem === 1'b1 && n < BOUND) begin
            cycle();
            n++;
        end
        check({tag, " stall_cycles"}, n, 1 + LATENCY);
        if (we) begin
            model_mem[addr[7:2]] = wdata;
            check({tag, " rdata_held"}, rdata, last_rdata);
        end else begin
            last_rdata = sb.pop_front();
            check({tag, " rdata"}, rdata, last_rdata);
        end
        check({tag, " test_value"}, {16'h0, test_value}, {16'h0, model_mem[0][15:0]});
        check({tag, " misalign"}, {31'h0, misalign_err}, {31'h0, exp_mis});
        req_valid = 1'b0;
        cycle();
    endtask

    logic [7:0] stall_pat;
    int         n;

    initial begin
        total     = 0;
        passed    = 0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        model_reset();

        // Reset then idle.
        cycle();
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("idle rdata", rdata, 32'h0);
            check("idle stall", {31'h0, stall_mem}, 32'h0);
            check("idle test_value", {16'h0, test_value}, 32'h0);
            check("idle misalign", {31'h0, misalign_err}, 32'h0);
            cycle();
        end

        // Store then load word 0.
        access(1'b1, 32'h0000_0000, 32'hDEAD_BEEF, "st0");
        access(1'b0, 32'h0000_0000, 32'h0, "ld0");

        // Address wrap and misalignment.
        access(1'b1, 32'h0000_0104, 32'h1234_5678, "st_wrap");
        access(1'b0, 32'h0000_0004, 32'h0, "ld_wrap");
        access(1'b0, 32'h0000_0006, 32'h0, "ld_misalign");
        for (int i = 0; i < 10; i++) begin
            check("misalign sticky", {31'h0, misalign_err}, 32'h1);
            cycle();
        end
        check("rdata after idle", rdata, 32'h1234_5678);

        // Back-to-back stores with req_valid held high.
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h0000_0008;
        req_wdata = 32'h0000_0001;
        for (int i = 0; i < 8; i++) begin
            #1;
            stall_pat[7-i] = stall_mem;
            if (i == 3) begin
                req_addr  = 32'h0000_000C;
                req_wdata = 32'h0000_0002;
            end
            if (i == 7) req_valid = 1'b0;
            cycle();
        end
        check("b2b stall pattern", {24'h0, stall_pat}, {24'h0, 8'b1110_1110});
        model_mem[2] = 32'h1;
        model_mem[3] = 32'h2;
        access(1'b0, 32'h0000_0008, 32'h0, "ld_b2b_a");
        access(1'b0, 32'h0000_000C, 32'h0, "ld_b2b_b");

        // Reset in the second BUSY cycle of a store.
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h0000_0010;
        req_wdata = 32'h0000_00AA;
        cycle();
        cycle();
        rst       = 1'b1;
        req_valid = 1'b0;
        cycle();
        rst = 1'b0;
        model_reset();
        #1;
        check("post-rst stall", {31'h0, stall_mem}, 32'h0);
        check("post-rst rdata", rdata, 32'h0);
        check("post-rst test_value", {16'h0, test_value}, 32'h0);
        check("post-rst misalign", {31'h0, misalign_err}, 32'h0);
        access(1'b0, 32'h0000_0010, 32'h0, "ld_after_rst");

        // Inputs change during BUSY; captured values must be used.
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h0000_0020;
        req_wdata = 32'h5A5A_5A5A;
        cycle();
        req_addr  = 32'h0000_0024;
        req_wdata = 32'h0000_00FF;
        n = 1;
        #1;
        while (stall_mem === 1'b1 && n < BOUND) begin
            cycle();
            n++;
        end
        check("hold stall_cycles", n, 1 + LATENCY);
        req_valid = 1'b0;
        cycle();
        model_mem[8] = 32'h5A5A_5A5A;
        access(1'b0, 32'h0000_0020, 32'h0, "ld_hold_a");
        access(1'b0, 32'h0000_0024, 32'h0, "ld_hold_b");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle data-memory responder serving load/store requests from the pipeline's Memory stage.
- Replaces the single-cycle data memory with a fixed-latency word store that stalls the pipeline while an access is outstanding.
- Drives stall_mem to the hazard unit, read data back to the M/W pipeline register, and the 16-bit test_value debug tap.

Parameters:
DEPTH, 64, number of 32-bit words in the store
ADDR_W, 6, word-index width; DEPTH = 2**ADDR_W
LATENCY, 2, BUSY cycles per access; legal range 1..15
CNT_W, 4, latency counter width

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  1  Memory stage holds a load or store (MemtoRegM | MemWriteM); held stable by pipeline while stall_mem=1
req_we  input  1  1 = store, 0 = load (MemWriteM)
req_addr  input  32  byte address (ALUOutM)
req_wdata  input  32  store data (WriteDataM)
rdata  output  32  registered load data (ReadDataM)
stall_mem  output  1  pipeline stall request to hazard unit
misalign_err  output  1  sticky flag: request seen with req_addr[1:0] != 0
test_value  output  16  mem[0][15:0], continuous

Behaviour:
- States: IDLE, BUSY, DONE. Registers: state, cnt[CNT_W-1:0], cap_we, cap_idx[ADDR_W-1:0], cap_wdata, rdata, misalign_err, mem[DEPTH].
- Reset (clk edge with rst=1): state=IDLE, cnt=0, rdata=0, misalign_err=0, all mem words=0, so test_value=0; stall_mem=0 in the following cycle unless req_valid=1. Reset overrides any in-flight access: a pending store is dropped and no write occurs.
- stall_mem = (state==IDLE & req_valid) | (state==BUSY). This is combinational, so the stall is visible in the same cycle the request appears.
- IDLE & req_valid: capture req_we, req_addr[ADDR_W+1:2], req_wdata; cnt<=LATENCY-1; set misalign_err if req_addr[1:0]!=0; go to BUSY. IDLE & !req_valid: stay in IDLE.
- BUSY & cnt!=0: cnt<=cnt-1.
- BUSY & cnt==0: perform the access. A store writes mem[cap_idx]<=cap_wdata and leaves rdata unchanged. A load sets rdata<=mem[cap_idx]. Then go to DONE.
- DONE: stall_mem=0 and rdata is valid, so the pipeline advances at this edge. Next state is IDLE unconditionally; req_valid in DONE is treated as the same, already-served request.
- Timing per access: 1 + LATENCY stall cycles, then 1 DONE cycle. Back-to-back requests are served with one IDLE cycle between the DONE of the first and the start of the next; that IDLE cycle stalls immediately.
- Addressing: word-aligned index req_addr[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH*4. A misaligned access is still performed at the truncated word index.
- misalign_err stays at 1 until rst.
- rdata holds its last load value across stores and idle cycles.
- req_addr/req_wdata changes during BUSY have no effect (captured values are used).
- req_valid dropping during BUSY does not abort the access; it completes normally.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then req_valid=0 for 5 cycles -> rdata=0, stall_mem=0, test_value=0, misalign_err=0 throughout.
- Store then load, LATENCY=2: store addr=0x0, wdata=0xDEADBEEF -> stall_mem high for exactly 3 cycles, DONE on the 4th, test_value=0xBEEF after the write edge. Then load addr=0x0 -> rdata=0xDEADBEEF in its DONE cycle.
- Wrap and misalign: store addr=0x104, data=0x12345678 (DEPTH=64 gives index 1); load addr=0x4 -> rdata=0x12345678. Load addr=0x6 -> misalign_err=1, rdata=0x12345678, and misalign_err remains 1 over 10 more idle cycles.
- Back-to-back: req_valid held high across two stores (addr 0x8 data 0x1, addr 0xC data 0x2), changing inputs in DONE -> cycle-exact stall pattern 1,1,1,0,1,1,1,0; loads confirm mem[2]=1, mem[3]=2.
- Reset mid-operation: store addr=0x10 data=0xAA, assert rst in the 2nd BUSY cycle -> next cycle state IDLE, stall_mem=0 with req_valid=0; subsequent load addr=0x10 -> rdata=0.
- Input hold check: during BUSY of a store to 0x20, change req_addr to 0x24 and req_wdata to 0xFF -> only mem[8] is written (with the original data); a load of 0x24 returns 0.
